axil_npc_regs_slave: RTL and testbench



---
 rtl/npc_regs_pkg.sv | 30 +++
 rtl/axil_wstrb_merge.sv | 22 ++
 rtl/axil_npc_regs_slave.sv | 183 ++++++++++++++++++
 tb/tb_axil_npc_regs_slave.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_regs_pkg.sv
// Shared constants and FSM state types for the NPC decoder register slave.
package npc_regs_pkg;

   // Register map: word offsets of the four decoder control registers
   localparam int NUM_REGS = 4;
   localparam int REG0_IDX = 0;
   localparam int REG1_IDX = 1;
   localparam int REG2_IDX = 2;
   localparam int REG3_IDX = 3;

   // Byte address bits below the word index
   localparam int ADDR_LSB = 2;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ACK  = 2'd1,
      W_RESP = 2'd2
   } wstate_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ACK  = 2'd1,
      R_DATA = 2'd2
   } rstate_e;

endpackage

// File: rtl/axil_wstrb_merge.sv
// Byte-lane merge: lanes enabled in the strobe take new write data,
// the remaining lanes keep the register's current value.
module axil_wstrb_merge #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   old_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   output logic [DATA_W-1:0]   merged_o
);

   // Start from the old value and overwrite only strobed lanes
   always_comb begin
      merged_o = old_i;
      for (int k = 0; k < DATA_W / 8; k++) begin
         if (wstrb_i[k]) begin
            merged_o[8*k +: 8] = wdata_i[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/axil_npc_regs_slave.sv
// AXI4-Lite slave holding the four control registers of the 3-level NPC
// decoder. Write and read channels run independent three-state FSMs.
// Optional feature macro: NPC_REGS_SLVERR_EN (SLVERR on unmapped accesses).
module axil_npc_regs_slave
   import npc_regs_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
   output logic [NUM_REGS-1:0]             reg_wr_pulse_o
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
   localparam int SEL_W = $clog2(NUM_REGS);
   localparam int DW    = C_S_AXI_DATA_WIDTH;

   wstate_e           wrState_q, wrState_d;
   rstate_e           rdState_q, rdState_d;

   logic [DW-1:0]     regFile_q [NUM_REGS];
   logic [DW-1:0]     merged    [NUM_REGS];
   logic [NUM_REGS-1:0] wrPulse_q, wrSel;
   logic [1:0]        bresp_q, bresp_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [DW-1:0]     rdata_q, rdata_d;

   logic [IDX_W-1:0]  wrIdx, rdIdx;
   logic              wrMapped, rdMapped;
   logic              wrHandshake, rdHandshake;

   // Protection bits and the byte offset inside a word carry no meaning here
   logic              unusedInputs;
   assign unusedInputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

   assign wrIdx       = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
   assign rdIdx       = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
   assign wrMapped    = (wrIdx < IDX_W'(NUM_REGS));
   assign rdMapped    = (rdIdx < IDX_W'(NUM_REGS));
   assign wrHandshake = (wrState_q == W_ACK);
   assign rdHandshake = (rdState_q == R_ACK);

   // Handshake and valid outputs decode directly from the state flops
   assign S_AXI_AWREADY  = wrHandshake;
   assign S_AXI_WREADY   = wrHandshake;
   assign S_AXI_BVALID   = (wrState_q == W_RESP);
   assign S_AXI_BRESP    = bresp_q;
   assign S_AXI_ARREADY  = rdHandshake;
   assign S_AXI_RVALID   = (rdState_q == R_DATA);
   assign S_AXI_RDATA    = rdata_q;
   assign S_AXI_RRESP    = rresp_q;
   assign reg0_o         = regFile_q[REG0_IDX];
   assign reg1_o         = regFile_q[REG1_IDX];
   assign reg2_o         = regFile_q[REG2_IDX];
   assign reg3_o         = regFile_q[REG3_IDX];
   assign reg_wr_pulse_o = wrPulse_q;

   // One lane-merge instance per register, all fed by the write data bus
   for (genvar g = 0; g < NUM_REGS; g++) begin : gMerge
      axil_wstrb_merge #(.DATA_W(DW)) uMerge (
         .old_i    (regFile_q[g]),
         .wdata_i  (S_AXI_WDATA),
         .wstrb_i  (S_AXI_WSTRB),
         .merged_o (merged[g])
      );
   end

   // Response codes for unmapped word slots
`ifdef NPC_REGS_SLVERR_EN
   assign bresp_d = wrMapped ? RESP_OKAY : RESP_SLVERR;
   assign rresp_d = rdMapped ? RESP_OKAY : RESP_SLVERR;
`else
   assign bresp_d = RESP_OKAY;
   assign rresp_d = RESP_OKAY;
`endif

   // Write FSM next state: accept only when both AW and W are presented
   always_comb begin
      wrState_d = wrState_q;
      case (wrState_q)
         W_IDLE:  if (S_AXI_AWVALID && S_AXI_WVALID) wrState_d = W_ACK;
         W_ACK:   wrState_d = W_RESP;
         W_RESP:  if (S_AXI_BREADY) wrState_d = W_IDLE;
         default: wrState_d = W_IDLE;
      endcase
   end

   // Read FSM next state
   always_comb begin
      rdState_d = rdState_q;
      case (rdState_q)
         R_IDLE:  if (S_AXI_ARVALID) rdState_d = R_ACK;
         R_ACK:   rdState_d = R_DATA;
         R_DATA:  if (S_AXI_RREADY) rdState_d = R_IDLE;
         default: rdState_d = R_IDLE;
      endcase
   end

   // One-hot select of the register written in the handshake cycle
   always_comb begin
      wrSel = '0;
      if (wrHandshake && wrMapped) begin
         wrSel[wrIdx[SEL_W-1:0]] = 1'b1;
      end
   end

   // Read data mux samples the registers before any same-cycle write lands
   always_comb begin
      rdata_d = '0;
      if (rdMapped) begin
         rdata_d = regFile_q[rdIdx[SEL_W-1:0]];
      end
   end

   // State registers for both channels
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wrState_q <= W_IDLE;
         rdState_q <= R_IDLE;
      end else begin
         wrState_q <= wrState_d;
         rdState_q <= rdState_d;
      end
   end

   // Register file, update strobes and write response capture
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regFile_q[i] <= '0;
         end
         wrPulse_q <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         wrPulse_q <= wrSel;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wrSel[i]) begin
               regFile_q[i] <= merged[i];
            end
         end
         if (wrHandshake) begin
            bresp_q <= bresp_d;
         end
      end
   end

   // Read data and response captured once, held while RVALID is up
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (rdHandshake) begin
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
      end
   end

endmodule

// File: tb/tb_axil_npc_regs_slave.sv
// Directed bench for axil_npc_regs_slave; honours NPC_REGS_SLVERR_EN.
`timescale 1ns/1ps
module tb_axil_npc_regs_slave;

   logic        clk;
   logic        rstN;
   logic [4:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [4:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;
   logic [31:0] reg0, reg1, reg2, reg3;
   logic [3:0]  wrPulse;

   int checks   = 0;
   int failures = 0;

`ifdef NPC_REGS_SLVERR_EN
   localparam logic [1:0] UNMAPPED_RESP = 2'b10;
`else
   localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif

   axil_npc_regs_slave dut (
      .S_AXI_ACLK     (clk),
      .S_AXI_ARESETN  (rstN),
      .S_AXI_AWADDR   (awaddr),
      .S_AXI_AWPROT   (awprot),
      .S_AXI_AWVALID  (awvalid),
      .S_AXI_AWREADY  (awready),
      .S_AXI_WDATA    (wdata),
      .S_AXI_WSTRB    (wstrb),
      .S_AXI_WVALID   (wvalid),
      .S_AXI_WREADY   (wready),
      .S_AXI_BRESP    (bresp),
      .S_AXI_BVALID   (bvalid),
      .S_AXI_BREADY   (bready),
      .S_AXI_ARADDR   (araddr),
      .S_AXI_ARPROT   (arprot),
      .S_AXI_ARVALID  (arvalid),
      .S_AXI_ARREADY  (arready),
      .S_AXI_RDATA    (rdata),
      .S_AXI_RRESP    (rresp),
      .S_AXI_RVALID   (rvalid),
      .S_AXI_RREADY   (rready),
      .reg0_o         (reg0),
      .reg1_o         (reg1),
      .reg2_o         (reg2),
      .reg3_o         (reg3),
      .reg_wr_pulse_o (wrPulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single write with AW and W together; ok requires exact latency
   task automatic doWrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [3:0] pulse, output bit ok);
      int n;
      ok = 1'b0; resp = 2'b11; pulse = 4'hx;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
      if (awready && wready && n == 1) ok = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      if (!bvalid) ok = 1'b0;
      resp = bresp; pulse = wrPulse;
      @(posedge clk); #1;
      if (bvalid || wrPulse !== 4'b0000) ok = 1'b0;
   endtask

   // Single read; ok requires ARREADY at N+1, RVALID at N+2, then drop
   task automatic doRead(input logic [4:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output bit ok);
      int n;
      ok = 1'b0; d = 32'hx; resp = 2'b11;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
      if (arready && n == 1) ok = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      if (!rvalid) ok = 1'b0;
      d = rdata; resp = rresp;
      @(posedge clk); #1;
      if (rvalid) ok = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] obs [11];
      rstN = 1'b0;
      awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstN = 1'b1;
      @(posedge clk); #1;
      obs = '{32'(awready), 32'(wready), 32'(bvalid), 32'(bresp), 32'(arready),
              32'(rvalid), rdata, 32'(rresp), reg0 | reg1, reg2 | reg3, 32'(wrPulse)};
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (obs[i] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_out%0d got=%h expected=%h", i, obs[i], 32'h0);
         end
      end
   endtask

   task automatic test_seq_write_read();
      logic [1:0]  resp;
      logic [3:0]  pulse;
      logic [31:0] d;
      logic [31:0] regs;
      bit          ok;
      for (int i = 0; i < 4; i++) begin
         doWrite(5'(4 * i), 32'(i + 1), 4'hF, resp, pulse, ok);
         case (i)
            0: regs = reg0;
            1: regs = reg1;
            2: regs = reg2;
            default: regs = reg3;
         endcase
         checks++;
         if (!ok || resp !== 2'b00 || pulse !== 4'(1 << i) || regs !== 32'(i + 1)) begin
            failures++;
            $display("[TB] FAIL seq_write%0d ok=%0d resp=%b pulse=%b reg=%h expected resp=00 pulse=%b reg=%h",
                     i, ok, resp, pulse, regs, 4'(1 << i), 32'(i + 1));
         end
      end
      for (int i = 0; i < 4; i++) begin
         doRead(5'(4 * i), d, resp, ok);
         checks++;
         if (!ok || resp !== 2'b00 || d !== 32'(i + 1)) begin
            failures++;
            $display("[TB] FAIL seq_read%0d ok=%0d resp=%b data=%h expected resp=00 data=%h",
                     i, ok, resp, d, 32'(i + 1));
         end
      end
   endtask

   task automatic test_wstrb();
      logic [1:0]  resp;
      logic [3:0]  pulse;
      logic [31:0] d;
      bit          ok;
      doWrite(5'h04, 32'hAABBCCDD, 4'b0101, resp, pulse, ok);
      checks++;
      if (!ok || resp !== 2'b00 || pulse !== 4'b0010 || reg1 !== 32'h00BB00DD) begin
         failures++;
         $display("[TB] FAIL wstrb_write ok=%0d resp=%b pulse=%b reg1=%h expected reg1=00bb00dd", ok, resp, pulse, reg1);
      end
      doRead(5'h05, d, resp, ok);
      checks++;
      if (!ok || d !== 32'h00BB00DD) begin
         failures++;
         $display("[TB] FAIL wstrb_read ok=%0d data=%h expected=00bb00dd", ok, d);
      end
   endtask

   task automatic test_split_handshake();
      int readyCount;
      int n;
      readyCount = 0;
      awaddr = 5'h00; wdata = 32'h12345678; wstrb = 4'hF; bready = 1'b0;
      awvalid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (awready || wready) readyCount++;
      end
      wvalid = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
      checks++;
      if (!(awready && wready) || n != 1 || readyCount != 0) begin
         failures++;
         $display("[TB] FAIL split_ready awready=%b wready=%b cycles=%0d early=%0d expected 1 1 1 0",
                  awready, wready, n, readyCount);
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL split_bhold%0d bvalid=%b bresp=%b awready=%b expected 1 00 0", c, bvalid, bresp, awready);
         end
         if (c < 4) begin @(posedge clk); #1; end
      end
      bready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bvalid !== 1'b0 || reg0 !== 32'h12345678) begin
         failures++;
         $display("[TB] FAIL split_done bvalid=%b reg0=%h expected 0 12345678", bvalid, reg0);
      end
   endtask

   task automatic test_unmapped();
      logic [1:0]  resp;
      logic [3:0]  pulse;
      logic [31:0] d;
      bit          ok;
      doWrite(5'h14, 32'hDEADBEEF, 4'hF, resp, pulse, ok);
      checks++;
      if (!ok || resp !== UNMAPPED_RESP || pulse !== 4'b0000 || reg0 !== 32'h12345678 ||
          reg1 !== 32'h00BB00DD || reg2 !== 32'h3 || reg3 !== 32'h4) begin
         failures++;
         $display("[TB] FAIL unmapped_write ok=%0d resp=%b pulse=%b regs=%h %h %h %h expected resp=%b",
                  ok, resp, pulse, reg0, reg1, reg2, reg3, UNMAPPED_RESP);
      end
      doRead(5'h14, d, resp, ok);
      checks++;
      if (!ok || resp !== UNMAPPED_RESP || d !== 32'h0) begin
         failures++;
         $display("[TB] FAIL unmapped_read ok=%0d resp=%b data=%h expected resp=%b data=0", ok, resp, d, UNMAPPED_RESP);
      end
   endtask

   task automatic test_concurrent();
      logic [1:0]  resp;
      logic [31:0] d;
      bit          ok;
      awaddr = 5'h08; wdata = 32'h55; wstrb = 4'hF; araddr = 5'h08;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (awready !== 1'b1 || arready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL concur_ready awready=%b arready=%b expected 1 1", awready, arready);
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h3 || bvalid !== 1'b1 || reg2 !== 32'h55) begin
         failures++;
         $display("[TB] FAIL concur_old rvalid=%b rdata=%h bvalid=%b reg2=%h expected 1 3 1 55",
                  rvalid, rdata, bvalid, reg2);
      end
      @(posedge clk); #1;
      doRead(5'h08, d, resp, ok);
      checks++;
      if (!ok || d !== 32'h55) begin
         failures++;
         $display("[TB] FAIL concur_new ok=%0d data=%h expected=55", ok, d);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp;
      logic [3:0] pulse;
      bit         ok;
      awaddr = 5'h04; wdata = 32'h77; wstrb = 4'hF; araddr = 5'h00;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b1 || rvalid !== 1'b1 || reg1 !== 32'h77) begin
         failures++;
         $display("[TB] FAIL rstmid_pre bvalid=%b rvalid=%b reg1=%h expected 1 1 77", bvalid, rvalid, reg1);
      end
      #2 rstN = 1'b0;
      #1;
      checks++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0 || (reg0 | reg1 | reg2 | reg3) !== 32'h0 || rdata !== 32'h0) begin
         failures++;
         $display("[TB] FAIL rstmid_clear bvalid=%b rvalid=%b regs=%h %h %h %h rdata=%h expected all 0",
                  bvalid, rvalid, reg0, reg1, reg2, reg3, rdata);
      end
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
      @(posedge clk); #1;
      doWrite(5'h0C, 32'hCAFEF00D, 4'hF, resp, pulse, ok);
      checks++;
      if (!ok || resp !== 2'b00 || pulse !== 4'b1000 || reg3 !== 32'hCAFEF00D || reg1 !== 32'h0) begin
         failures++;
         $display("[TB] FAIL rstmid_fresh ok=%0d resp=%b pulse=%b reg3=%h reg1=%h expected 00 1000 cafef00d 0",
                  ok, resp, pulse, reg3, reg1);
      end
   endtask

   // Hard stop if the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] timeout");
   end

   // Scenario sequence
   initial begin
      test_reset();
      test_seq_write_read();
      test_wstrb();
      test_split_handshake();
      test_unmapped();
      test_concurrent();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
